// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10,
        ERR_PARITY   = 2'b11
    } imem_err_e;

    typedef struct packed {
        logic [31:0] instr;
        imem_err_e   err;
    } imem_rsp_t;

    // Even parity: the stored bit makes the total number of ones even.
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Circular response queue of imem_rsp_t with wrap-around pointers and
// full/empty flags; DEPTH need not be a power of two.
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  imem_rsp_t        din,
    input  logic             pop,
    output imem_rsp_t        dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    imem_rsp_t        slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            slots[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: in-order fetch responses with 1-cycle read
// latency and a loader write port. Define IMEM_PARITY_EN for per-word parity.
module imem_responder
    import imem_pkg::*;
#(
    parameter  int          DEPTH     = 256,
    parameter  logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter  int          RSP_DEPTH = 2,
    localparam int          ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_instr,
    output logic [1:0]        rsp_err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
`ifdef IMEM_PARITY_EN
    input  logic              wr_par_inject,
`endif
    output logic [15:0]       err_count
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
`ifdef IMEM_PARITY_EN
    localparam int MEM_W = 33;
`else
    localparam int MEM_W = 32;
`endif

    logic [MEM_W-1:0]  mem [DEPTH];
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;

    logic [32:0]       addr_diff;
    logic [31:0]       offset;
    logic              misaligned;
    logic              out_of_range;
    imem_err_e         req_err;
    logic [ADDR_W-1:0] req_idx;
    logic              accept;

    logic              rd_pending;
    imem_err_e         rd_err;
    imem_rsp_t         rd_rsp;

    logic              fifo_push;
    logic              fifo_pop;
    imem_rsp_t         fifo_dout;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  occ;
    imem_rsp_t         head;
    logic              consume;

    // Address check; bit 32 of the difference is the borrow for req_addr < BASE_ADDR.
    assign addr_diff    = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign offset       = addr_diff[31:0];
    assign misaligned   = (req_addr[1:0] != 2'b00);
    assign out_of_range = addr_diff[32] || ((offset >> 2) >= 32'(DEPTH));
    assign req_idx      = offset[ADDR_W+1:2];

    always_comb begin
        req_err = ERR_OK;
        if (misaligned) begin
            req_err = ERR_MISALIGN;
        end else if (out_of_range) begin
            req_err = ERR_RANGE;
        end
    end

    assign occ       = fifo_count + CNT_W'(rd_pending);
    assign req_ready = !fifo_full && (occ < CNT_W'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;

`ifdef IMEM_PARITY_EN
    assign wr_word = {even_parity(wr_data) ^ wr_par_inject, wr_data};
`else
    assign wr_word = wr_data;
`endif

    // Non-blocking write and read in one block gives read-first on a collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
        if (accept && (req_err == ERR_OK)) begin
            rd_word <= mem[req_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending <= 1'b0;
            rd_err     <= ERR_OK;
        end else begin
            rd_pending <= accept;
            if (accept) begin
                rd_err <= req_err;
            end
        end
    end

    always_comb begin
        rd_rsp.instr = NOP_INSTR;
        rd_rsp.err   = rd_err;
        if (rd_err == ERR_OK) begin
`ifdef IMEM_PARITY_EN
            if (^rd_word) begin
                rd_rsp.err = ERR_PARITY;
            end else begin
                rd_rsp.instr = rd_word[31:0];
            end
`else
            rd_rsp.instr = rd_word;
`endif
        end
    end

    // The in-flight word bypasses the queue when the queue is empty, so the
    // response shows up the cycle after acceptance and streams at full rate.
    assign rsp_valid = rd_pending || !fifo_empty;
    assign head      = fifo_empty ? rd_rsp : fifo_dout;
    assign rsp_instr = head.instr;
    assign rsp_err   = head.err;
    assign consume   = rsp_valid && rsp_ready;
    assign fifo_pop  = !fifo_empty && rsp_ready;
    assign fifo_push = rd_pending && !(fifo_empty && rsp_ready);

    imem_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (rd_rsp),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (consume && (head.err != ERR_OK) && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder; inputs change and outputs are checked on
// the falling edge. Define IMEM_PARITY_EN to include the parity steps.
module tb_imem_responder;
    import imem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [1:0]  rsp_err;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_par_inject;
    logic [15:0] err_count;

    int checks   = 0;
    int failures = 0;

    imem_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_instr     (rsp_instr),
        .rsp_err       (rsp_err),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
`ifdef IMEM_PARITY_EN
        .wr_par_inject (wr_par_inject),
`endif
        .err_count     (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_addr      = 32'h0;
        rsp_ready     = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = 8'h0;
        wr_data       = 32'h0;
        wr_par_inject = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;

        // preload words 0..7 with 1..8
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 8'(i);
            wr_data = 32'(i + 1);
        end
        @(negedge clk);
        wr_en = 1'b0;

        // streaming at full rate
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("stream_req_ready", 32'(req_ready), 32'd1);
            if (k == 0) begin
                check("stream_idle", 32'(rsp_valid), 32'd0);
            end else begin
                check("stream_valid", 32'(rsp_valid), 32'd1);
                check("stream_instr", rsp_instr, 32'(k));
                check("stream_err", 32'(rsp_err), 32'd0);
            end
            req_valid = 1'b1;
            req_addr  = 32'(4 * k);
            @(negedge clk);
        end
        check("stream_valid_last", 32'(rsp_valid), 32'd1);
        check("stream_instr_last", rsp_instr, 32'd4);
        req_valid = 1'b0;
        @(negedge clk);
        check("stream_drained", 32'(rsp_valid), 32'd0);

        // backpressure: two accepts fill the queue
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h10;
        @(negedge clk);
        check("bp_ready_1", 32'(req_ready), 32'd1);
        check("bp_valid_1", 32'(rsp_valid), 32'd1);
        check("bp_instr_1", rsp_instr, 32'd5);
        req_addr = 32'h14;
        @(negedge clk);
        check("bp_ready_full", 32'(req_ready), 32'd0);
        check("bp_hold_a", rsp_instr, 32'd5);
        req_addr = 32'h18;
        @(negedge clk);
        check("bp_ready_still_full", 32'(req_ready), 32'd0);
        check("bp_hold_b", rsp_instr, 32'd5);
        check("bp_hold_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_instr_2", rsp_instr, 32'd6);
        check("bp_ready_freed", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("bp_instr_3", rsp_instr, 32'd7);
        check("bp_valid_3", 32'(rsp_valid), 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        check("bp_drained", 32'(rsp_valid), 32'd0);

        // address errors
        req_valid = 1'b1;
        req_addr  = 32'h6;
        @(negedge clk);
        check("mis_instr", rsp_instr, NOP_INSTR);
        check("mis_err", 32'(rsp_err), 32'd1);
        req_addr = 32'h400;
        @(negedge clk);
        check("rng_instr", rsp_instr, NOP_INSTR);
        check("rng_err", 32'(rsp_err), 32'd2);
        check("err_count_1", 32'(err_count), 32'd1);
        req_addr = 32'h402;
        @(negedge clk);
        check("prio_err", 32'(rsp_err), 32'd1);
        check("err_count_2", 32'(err_count), 32'd2);
        req_valid = 1'b0;
        @(negedge clk);
        check("err_count_3", 32'(err_count), 32'd3);
        check("err_drained", 32'(rsp_valid), 32'd0);

        // write/read collision returns old data
        wr_en     = 1'b1;
        wr_addr   = 8'd5;
        wr_data   = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        req_addr  = 32'h14;
        @(negedge clk);
        check("rw_old", rsp_instr, 32'd6);
        check("rw_old_err", 32'(rsp_err), 32'd0);
        wr_en = 1'b0;
        @(negedge clk);
        check("rw_new", rsp_instr, 32'hDEAD_BEEF);
        req_valid = 1'b0;
        @(negedge clk);

        // reset with two responses pending
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        @(negedge clk);
        req_addr = 32'h4;
        @(negedge clk);
        req_valid = 1'b0;
        check("pend_ready", 32'(req_ready), 32'd0);
        check("pend_instr", rsp_instr, 32'd1);
        check("pend_err_count", 32'(err_count), 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h8;
        @(negedge clk);
        check("post_rst_valid", 32'(rsp_valid), 32'd1);
        check("post_rst_instr", rsp_instr, 32'd3);
        check("post_rst_err", 32'(rsp_err), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        check("post_rst_drained", 32'(rsp_valid), 32'd0);

`ifdef IMEM_PARITY_EN
        wr_en         = 1'b1;
        wr_addr       = 8'd7;
        wr_data       = 32'h0000_0077;
        wr_par_inject = 1'b1;
        @(negedge clk);
        wr_en         = 1'b0;
        wr_par_inject = 1'b0;
        req_valid     = 1'b1;
        req_addr      = 32'h1C;
        @(negedge clk);
        check("par_instr", rsp_instr, NOP_INSTR);
        check("par_err", 32'(rsp_err), 32'd3);
        req_valid = 1'b0;
        wr_en     = 1'b1;
        @(negedge clk);
        wr_en     = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        check("par_fixed_instr", rsp_instr, 32'h0000_0077);
        check("par_fixed_err", 32'(rsp_err), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
